// File: rtl/aurora_link_chk_mc.sv
// rtl/aurora_link_chk_mc.sv - multi-channel Aurora RX sequence checker with hunt/lock and saturating stats
module aurora_link_chk_mc #(
  parameter int CH_NUM     = 4,
  parameter int DATA_WD    = 64,
  parameter int SEQ_WD     = 16,
  parameter int SEQ_LSB    = 0,
  parameter int LOCK_THR   = 4,
  parameter int UNLOCK_THR = 3,
  parameter int CNT_WD     = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_rst,
  input  logic [CH_NUM-1:0]          cfg_chk_en,
  input  logic [CH_NUM-1:0]          enc_vld,
  input  logic [CH_NUM*DATA_WD-1:0]  enc_data,
  output logic [CH_NUM-1:0]          lock,
  output logic [CH_NUM*CNT_WD-1:0]   suc_cnt,
  output logic [CH_NUM*CNT_WD-1:0]   err_cnt,
  output logic [CH_NUM*CNT_WD-1:0]   lost_cnt,
  output logic [CH_NUM-1:0]          err_flag
);

  localparam int GR_WD = $clog2(LOCK_THR + 1);
  localparam int BR_WD = $clog2(UNLOCK_THR + 1);

  localparam logic [CNT_WD-1:0] CNT_MAX    = '1;
  localparam logic [CNT_WD-1:0] CNT_ONE    = CNT_WD'(1);
  localparam logic [SEQ_WD-1:0] SEQ_ONE    = SEQ_WD'(1);
  localparam logic [GR_WD-1:0]  GR_ONE     = GR_WD'(1);
  localparam logic [GR_WD:0]    GR_ONE_X   = (GR_WD+1)'(1);
  localparam logic [BR_WD:0]    BR_ONE_X   = (BR_WD+1)'(1);
  localparam logic [GR_WD:0]    GOOD_LOCK  = (GR_WD+1)'(LOCK_THR);
  localparam logic [BR_WD:0]    BAD_UNLOCK = (BR_WD+1)'(UNLOCK_THR);

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

  function automatic logic [CNT_WD-1:0] sat_inc(input logic [CNT_WD-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_ONE;
  endfunction

  // Bits outside the sequence field are payload and deliberately not inspected.
  logic unused_data;
  assign unused_data = ^enc_data;

  for (genvar ch = 0; ch < CH_NUM; ch++) begin : g_ch
    state_t              state;
    logic [SEQ_WD-1:0]   expected;
    logic [SEQ_WD-1:0]   seq;
    logic [GR_WD-1:0]    good_run;
    logic [BR_WD-1:0]    bad_run;
    logic [CNT_WD-1:0]   suc;
    logic [CNT_WD-1:0]   err;
    logic [CNT_WD-1:0]   lost;
    logic                flag;
    logic                match;
    logic [GR_WD:0]      good_nxt;
    logic [BR_WD:0]      bad_nxt;

    assign seq      = enc_data[ch*DATA_WD+SEQ_LSB +: SEQ_WD];
    assign match    = (seq == expected);
    // A mismatching beat in HUNT is itself the first candidate of a new run.
    assign good_nxt = match ? ({1'b0, good_run} + GR_ONE_X) : GR_ONE_X;
    assign bad_nxt  = {1'b0, bad_run} + BR_ONE_X;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state    <= HUNT;
        expected <= '0;
        good_run <= '0;
        bad_run  <= '0;
        suc      <= '0;
        err      <= '0;
        lost     <= '0;
        flag     <= 1'b0;
      end else if (cfg_rst) begin
        state    <= HUNT;
        expected <= '0;
        good_run <= '0;
        bad_run  <= '0;
        suc      <= '0;
        err      <= '0;
        lost     <= '0;
        flag     <= 1'b0;
      end else if (!cfg_chk_en[ch]) begin
        state    <= HUNT;
        good_run <= '0;
        bad_run  <= '0;
      end else if (enc_vld[ch]) begin
        expected <= seq + SEQ_ONE;
        case (state)
          HUNT: begin
            if (good_nxt == GOOD_LOCK) begin
              state    <= LOCKED;
              good_run <= '0;
            end else begin
              good_run <= good_nxt[GR_WD-1:0];
            end
          end
          LOCKED: begin
            if (match) begin
              suc     <= sat_inc(suc);
              bad_run <= '0;
            end else begin
              err  <= sat_inc(err);
              flag <= 1'b1;
              if (bad_nxt == BAD_UNLOCK) begin
                state    <= HUNT;
                lost     <= sat_inc(lost);
                bad_run  <= '0;
                good_run <= GR_ONE;
              end else begin
                bad_run <= bad_nxt[BR_WD-1:0];
              end
            end
          end
          default: state <= HUNT;
        endcase
      end
    end

    assign lock[ch]                         = (state == LOCKED);
    assign err_flag[ch]                     = flag;
    assign suc_cnt[ch*CNT_WD +: CNT_WD]     = suc;
    assign err_cnt[ch*CNT_WD +: CNT_WD]     = err;
    assign lost_cnt[ch*CNT_WD +: CNT_WD]    = lost;
  end

endmodule

// File: tb/tb_aurora_link_chk_mc.sv
// tb/tb_aurora_link_chk_mc.sv - randomized and directed bench for aurora_link_chk_mc against a behavioural model
module tb_aurora_link_chk_mc;
  localparam int CH = 4, DW = 64, SW = 16, LT = 4, UT = 3, CW = 32, CWS = 4;

  logic clk = 1'b0;
  logic rst, cfg_rst;
  logic [CH-1:0] en, vld;
  logic [CH*DW-1:0] data;
  logic [CH-1:0] lock_a, flag_a, lock_b, flag_b;
  logic [CH*CW-1:0] suc_a, err_a, lost_a;
  logic [CH*CWS-1:0] suc_b, err_b, lost_b;

  always #5 clk = ~clk;

  aurora_link_chk_mc u_dut (
    .clk(clk), .rst(rst), .cfg_rst(cfg_rst), .cfg_chk_en(en), .enc_vld(vld), .enc_data(data),
    .lock(lock_a), .suc_cnt(suc_a), .err_cnt(err_a), .lost_cnt(lost_a), .err_flag(flag_a)
  );

  aurora_link_chk_mc #(.CNT_WD(CWS)) u_sat (
    .clk(clk), .rst(rst), .cfg_rst(cfg_rst), .cfg_chk_en(en), .enc_vld(vld), .enc_data(data),
    .lock(lock_b), .suc_cnt(suc_b), .err_cnt(err_b), .lost_cnt(lost_b), .err_flag(flag_b)
  );

  int tests = 0, fails = 0;
  bit chk_on = 1'b0;

  // Model keeps unbounded counts; each DUT instance sees them clipped to its width.
  bit             m_lock[CH], m_flag[CH];
  logic [SW-1:0]  m_exp[CH];
  int             m_good[CH], m_bad[CH];
  longint         m_suc[CH], m_err[CH], m_lost[CH];

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint sat(input longint c, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (c > mx) ? mx : c;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < CH; i++) begin
      m_lock[i] = 0; m_flag[i] = 0; m_exp[i] = '0; m_good[i] = 0; m_bad[i] = 0;
      m_suc[i] = 0; m_err[i] = 0; m_lost[i] = 0;
    end
  endtask

  task automatic model_step();
    logic [SW-1:0] s;
    if (rst || cfg_rst) begin
      model_clear();
      return;
    end
    for (int i = 0; i < CH; i++) begin
      s = data[i*DW +: SW];
      if (!en[i]) begin
        m_lock[i] = 0; m_good[i] = 0; m_bad[i] = 0;
      end else if (vld[i]) begin
        if (!m_lock[i]) begin
          m_good[i] = (s == m_exp[i]) ? m_good[i] + 1 : 1;
          if (m_good[i] >= LT) begin m_lock[i] = 1; m_good[i] = 0; end
        end else if (s == m_exp[i]) begin
          m_suc[i]++; m_bad[i] = 0;
        end else begin
          m_err[i]++; m_flag[i] = 1; m_bad[i]++;
          if (m_bad[i] >= UT) begin
            m_lock[i] = 0; m_lost[i]++; m_bad[i] = 0; m_good[i] = 1;
          end
        end
        m_exp[i] = s + SW'(1);
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < CH; i++) begin
        check($sformatf("lock_a[%0d]", i), longint'(lock_a[i]), longint'(m_lock[i]));
        check($sformatf("flag_a[%0d]", i), longint'(flag_a[i]), longint'(m_flag[i]));
        check($sformatf("suc_a[%0d]", i), longint'(suc_a[i*CW +: CW]), sat(m_suc[i], CW));
        check($sformatf("err_a[%0d]", i), longint'(err_a[i*CW +: CW]), sat(m_err[i], CW));
        check($sformatf("lost_a[%0d]", i), longint'(lost_a[i*CW +: CW]), sat(m_lost[i], CW));
        check($sformatf("lock_b[%0d]", i), longint'(lock_b[i]), longint'(m_lock[i]));
        check($sformatf("flag_b[%0d]", i), longint'(flag_b[i]), longint'(m_flag[i]));
        check($sformatf("suc_b[%0d]", i), longint'(suc_b[i*CWS +: CWS]), sat(m_suc[i], CWS));
        check($sformatf("err_b[%0d]", i), longint'(err_b[i*CWS +: CWS]), sat(m_err[i], CWS));
        check($sformatf("lost_b[%0d]", i), longint'(lost_b[i*CWS +: CWS]), sat(m_lost[i], CWS));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_beat(input int i, input bit v, input logic [SW-1:0] s);
    vld[i] = v;
    data[i*DW +: DW] = {$urandom, $urandom};
    data[i*DW +: SW] = s;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_lock"}, longint'(lock_a), 0);
    check({tag, "_flag"}, longint'(flag_a), 0);
    check({tag, "_suc"},  longint'(|suc_a), 0);
    check({tag, "_err"},  longint'(|err_a), 0);
    check({tag, "_lost"}, longint'(|lost_a), 0);
    check({tag, "_sat"},  longint'(|{suc_b, err_b, lost_b, lock_b, flag_b}), 0);
  endtask

  int seqs[CH][0:127];
  int len[CH], ptr[CH];
  logic [SW-1:0] nseq[CH];
  bit busy;

  initial begin
    rst = 1'b1; cfg_rst = 1'b0; en = '1; vld = '0; data = '0;
    model_clear();
    #12;
    check_all_zero("reset");
    rst = 1'b0;
    chk_on = 1'b1;

    // Directed per-channel streams with random idle gaps.
    for (int k = 0; k < 100; k++) seqs[0][k] = k;
    len[0] = 100;
    for (int k = 0; k < 4; k++) seqs[1][k] = 'hFFFC + k;
    for (int k = 0; k < 10; k++) seqs[1][4+k] = k;
    len[1] = 14;
    for (int k = 0; k < 6; k++) seqs[2][k] = 10 + k;
    seqs[2][6] = 40; seqs[2][7] = 41; seqs[2][8] = 42;
    len[2] = 9;
    for (int k = 0; k < 6; k++) seqs[3][k] = k;
    seqs[3][6] = 100; seqs[3][7] = 50; seqs[3][8] = 7;
    for (int k = 0; k < 4; k++) seqs[3][9+k] = 20 + k;
    len[3] = 13;
    for (int i = 0; i < CH; i++) ptr[i] = 0;
    busy = 1'b1;
    for (int c = 0; c < 2000 && busy; c++) begin
      busy = 1'b0;
      for (int i = 0; i < CH; i++) begin
        if (ptr[i] < len[i] && $urandom_range(0, 3) != 0) begin
          set_beat(i, 1'b1, SW'(seqs[i][ptr[i]]));
          ptr[i]++;
        end else begin
          set_beat(i, 1'b0, SW'($urandom));
        end
        if (ptr[i] < len[i]) busy = 1'b1;
      end
      tick();
    end
    vld = '0;
    tick();
    check("directed_done", longint'(busy), 0);
    check("d_lock", longint'(lock_a), 'hF);
    check("d_suc0", longint'(suc_a[0*CW +: CW]), 96);
    check("d_suc1", longint'(suc_a[1*CW +: CW]), 10);
    check("d_suc2", longint'(suc_a[2*CW +: CW]), 4);
    check("d_suc3", longint'(suc_a[3*CW +: CW]), 2);
    check("d_err0", longint'(err_a[0*CW +: CW]), 0);
    check("d_err1", longint'(err_a[1*CW +: CW]), 0);
    check("d_err2", longint'(err_a[2*CW +: CW]), 1);
    check("d_err3", longint'(err_a[3*CW +: CW]), 3);
    check("d_lost", longint'({lost_a[3*CW +: CW], lost_a[2*CW +: CW], lost_a[CW +: CW], lost_a[0 +: CW]} == {32'd1, 32'd0, 32'd0, 32'd0}), 1);
    check("d_flag", longint'(flag_a), 'hC);
    check("d_sat_suc0", longint'(suc_b[0 +: CWS]), 15);
    check("d_sat_suc1", longint'(suc_b[CWS +: CWS]), 10);

    // cfg_rst wins over a simultaneous beat on every channel.
    for (int i = 0; i < CH; i++) set_beat(i, 1'b1, m_exp[i]);
    cfg_rst = 1'b1;
    tick();
    cfg_rst = 1'b0; vld = '0;
    check_all_zero("cfg_rst");

    // Random streams: mostly contiguous, with slips, gaps, enable toggles and rare cfg_rst.
    for (int i = 0; i < CH; i++) nseq[i] = SW'($urandom);
    for (int c = 0; c < 1500; c++) begin
      cfg_rst = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < CH; i++) begin
        if ($urandom_range(0, 59) == 0) en[i] = ~en[i];
        if ($urandom_range(0, 3) != 0) begin
          if ($urandom_range(0, 11) == 0) nseq[i] = nseq[i] + SW'($urandom_range(2, 60000));
          set_beat(i, 1'b1, nseq[i]);
          nseq[i] = nseq[i] + SW'(1);
        end else begin
          set_beat(i, 1'b0, SW'($urandom));
        end
      end
      tick();
    end
    cfg_rst = 1'b0; en = '1; vld = '0;
    tick();

    // Dropping enable while locked: lock falls, lost_cnt and counters untouched.
    cfg_rst = 1'b1;
    tick();
    cfg_rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      set_beat(0, 1'b1, SW'(k));
      tick();
    end
    check("en_pre_lock", longint'(lock_a[0]), 1);
    en[0] = 1'b0;
    set_beat(0, 1'b1, SW'(77));
    tick();
    check("en_lock", longint'(lock_a[0]), 0);
    check("en_lost", longint'(lost_a[0 +: CW]), 0);
    check("en_suc", longint'(suc_a[0 +: CW]), 6);
    check("en_err", longint'(err_a[0 +: CW]), 0);
    en[0] = 1'b1;
    for (int k = 11; k < 20; k++) begin
      set_beat(0, 1'b1, SW'(k));
      tick();
    end
    check("en_relock", longint'(lock_a[0]), 1);

    // Async reset mid-stream clears outputs without waiting for a clock edge.
    rst = 1'b1;
    model_clear();
    #1;
    check_all_zero("async_rst");
    tick();
    rst = 1'b0; vld = '0;
    tick();
    tick();

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
